// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter: buffers pushed bytes and releases them as
// single-cycle transmit pulses spaced BYTE_CLKS clocks apart, flagging dropped pushes.
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BYTE_CLKS = 4400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic [7:0]              wr_data,
  input  logic                    clr_ovf,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    transmit,
  output logic [7:0]              data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(BYTE_CLKS);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [TW-1:0]   timer;
  logic            pop_c;
  logic            dec_c;
  logic            push_c;
  logic            drop_c;
  logic [CW-1:0]   count_nxt_c;

  // Pacer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pacer next state: leave IDLE on every pop, return once the slot timer expires
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = WAIT;
      WAIT:    if (timer == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pacer outputs
  always_comb begin
    pop_c = 1'b0;
    dec_c = 1'b0;
    case (state)
      IDLE:    pop_c = !empty;
      WAIT:    dec_c = (timer != '0);
      default: ;
    endcase
  end

  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign push_c = wr && (!full || pop_c);
  assign drop_c = wr && !push_c;

  always_comb begin
    count_nxt_c = count;
    if (push_c && !pop_c)      count_nxt_c = count + CW'(1);
    else if (pop_c && !push_c) count_nxt_c = count - CW'(1);
  end

  // Pointers, occupancy flags, overflow and transmit datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      transmit <= 1'b0;
      data     <= '0;
      timer    <= '0;
    end else begin
      count    <= count_nxt_c;
      full     <= (count_nxt_c == CW'(DEPTH));
      empty    <= (count_nxt_c == '0);
      transmit <= pop_c;
      if (push_c) wptr <= wptr + AW'(1);
      if (pop_c) begin
        rptr  <= rptr + AW'(1);
        data  <= mem[rptr];
        timer <= TW'(BYTE_CLKS - 2);
      end else if (dec_c) begin
        timer <= timer - TW'(1);
      end
      if (drop_c)       overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_c) mem[wptr] <= wr_data;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and pacer that sits directly upstream of the `uart` transmitter. Producers (byte counters, status reporters, future debug taps) push bytes at any rate. The block drains them one at a time as single-cycle `transmit` pulses with `data`, spaced so that each frame finishes before the next one starts. It replaces ad-hoc free-running send timers in `mojo_top`, and reports overflow instead of silently corrupting frames.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BYTE_CLKS`, 4400: clocks between consecutive `transmit` pulses; ≥ one full frame (10 bit times; 434 clk/bit at 50 MHz, 115200 baud); ≥2.

- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `wr`  in  1  push strobe; `wr_data` is captured on any rising edge where `wr`=1.
- `wr_data`  in  8  byte to push.
- `clr_ovf`  in  1  clears the sticky `overflow` flag.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a push is dropped.
- `transmit`  out  1  one-cycle send strobe to `uart.transmit`.
- `data`  out  8  byte to `uart.data`; valid with `transmit` and held until the next pulse.

## Operation
- Storage is a circular buffer of DEPTH×8 with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- `count` is a separate register. It does +1 on an accepted push alone, −1 on a pop alone, and is unchanged when both happen in the same cycle.
- `full`, `empty` and `count` are registered and reflect the state after the last edge.
- **Push rules:**
  - `wr` with `full`=0: the byte is stored and the write pointer advances.
  - `wr` with `full`=1 and a pop in the same cycle: the byte is accepted, and `count` stays at DEPTH.
  - `wr` with `full`=1 and no pop: the byte is dropped and `overflow` is set.
- `overflow` is set and cleared only as described here. `clr_ovf` clears it. A drop in the same cycle as `clr_ovf` wins, so `overflow` stays 1.
- **Pacer FSM:**
  - IDLE:
    - if `empty`=0: pop the head, load it into `data`, assert `transmit` for the next cycle, load `timer` = BYTE_CLKS−2, and go to WAIT.
    - otherwise stay in IDLE.
  - WAIT: decrement `timer`. When `timer`=0, go to IDLE.
  - `timer` is $clog2(BYTE_CLKS) bits wide.
- `transmit` and `data` are registered outputs. `transmit` is never high on two consecutive cycles.
- **Reset**, asynchronous at any time, including mid-WAIT:
  - pointers, `count`, `timer` and `data` go to 0;
  - `empty`=1, `full`=0, `overflow`=0, `transmit`=0;
  - the FSM goes to IDLE and buffered bytes are discarded.
- FIFO contents are not reset; they are don't-care until written.

## Timing
- **First byte:** `wr` sampled at edge k into an empty FIFO in IDLE → `empty`=0 after edge k. The pop happens at edge k+1, so `transmit`=1 with `data`=byte between edges k+1 and k+2.
- Push-to-`transmit` latency is 1 cycle after capture when idle.
- **Back-to-back bytes:** with the FIFO non-empty, successive `transmit` pulses are exactly BYTE_CLKS clocks apart (rising edge to rising edge).
- `count` decrements at the same edge at which `transmit` rises.
- A byte pushed while in WAIT is sent at the next slot, never earlier than BYTE_CLKS after the previous pulse.
- Throughput is at most one byte per BYTE_CLKS cycles. Sustained pushes faster than that fill the FIFO and then overflow.

## Test plan
- **Reset:** hold `rst_n`=0 with `wr` toggling.
  - Required: `transmit`=0, `data`=0, `count`=0, `empty`=1, `overflow`=0 throughout.
  - Release, then push 0xA5 at edge k → `transmit` high for exactly one cycle after edge k+1 with `data`=0xA5.
- **Burst:** push 0x01..0x05 on 5 consecutive clocks.
  - Required: 5 pulses in order 0x01..0x05, spaced exactly 4400 clks.
  - `count` peaks at 4 (the first byte pops immediately) and ends at 0 with `empty`=1.
- **Full/overflow:** DEPTH=4, BYTE_CLKS=20; push 6 bytes back-to-back.
  - Required: 4 bytes stored (the first pops at cycle 1, so `full` is reached), the last push is dropped, and `overflow`=1.
  - The sent sequence omits exactly the dropped byte.
- **Overflow clear:** pulse `clr_ovf` alone → `overflow`=0 next cycle.
  - `clr_ovf` and a dropped push in the same cycle → `overflow` stays 1.
- **Wrap-around:** DEPTH=4; push and drain 11 bytes (0x10..0x1A) in groups of 3.
  - Required: output order is exact with no gaps or duplicates, and `count` returns to 0.
- **Reset mid-operation:** with 3 bytes queued and the FSM in WAIT, pulse `rst_n` low for 1 cycle.
  - Required: no further `transmit`, `count`=0.
  - The next push is sent with first-byte latency.
